// File: rtl/ttl_counter_n.sv
// ttl_counter_n: parametrised 74F161/163/169-style counter with async clear/preset and RCO cascade
module ttl_counter_n #(
  parameter int WIDTH = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH,
  parameter int UPDOWN = 0,
  parameter longint unsigned PRESET_VAL = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             S,
  input  logic             SCLR_n,
  input  logic             LD_n,
  input  logic [WIDTH-1:0] D,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UD,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n,
  output logic             RCO
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] PV = WIDTH'(PRESET_VAL);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic             down;
  logic [WIDTH-1:0] step, nxt, clr_n, set_n;
  assign down = (UPDOWN != 0) && !UD;
  assign step = down ? (Q == '0 ? TOP : Q - ONE) : (Q == TOP ? '0 : Q + ONE);
  assign nxt = !SCLR_n ? '0 : !LD_n ? D : (ENP && ENT) ? step : Q;
  assign RCO = ENT && (Q == (down ? '0 : TOP));
  assign Q_n = ~Q;
  // Preset-1 bits see a fresh set edge when R rises while S is still low, so R-over-S release lands on PRESET_VAL
  assign clr_n = {WIDTH{R}} & ({WIDTH{S}} | PV);
  assign set_n = ~{WIDTH{R}} | {WIDTH{S}} | ~PV;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic b;
    always_ff @(posedge CLK or negedge clr_n[i] or negedge set_n[i])
      if (!clr_n[i]) b <= 1'b0;
      else if (!set_n[i]) b <= 1'b1;
      else b <= nxt[i];
    assign Q[i] = b;
  end
endmodule

// File: tb/tb_ttl_counter_n.sv
// tb_ttl_counter_n: scoreboard bench for binary, decade, up/down and cascaded counter instances
module tb_ttl_counter_n;
  logic clk = 1'b0, r = 1'b1, s = 1'b1, sclr_n = 1'b1, ld_n = 1'b1;
  logic enp = 1'b0, ent = 1'b0, ud = 1'b1;
  logic [3:0] d4 = 4'd0;
  logic [7:0] d8 = 8'd0;
  logic [3:0] a_q, a_qn, b_q, b_qn, e0_q, e0_qn, e1_q, e1_qn;
  logic [7:0] c_q, c_qn;
  logic a_rco, b_rco, c_rco, e0_rco, e1_rco;
  int errors = 0, checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  always #5 clk = ~clk;

  ttl_counter_n u_a (.CLK(clk), .R(r), .S(s), .SCLR_n(sclr_n), .LD_n(ld_n), .D(d4),
    .ENP(enp), .ENT(ent), .UD(ud), .Q(a_q), .Q_n(a_qn), .RCO(a_rco));
  ttl_counter_n #(.MODULUS(10), .UPDOWN(1)) u_b (.CLK(clk), .R(r), .S(s), .SCLR_n(sclr_n),
    .LD_n(ld_n), .D(d4), .ENP(enp), .ENT(ent), .UD(ud), .Q(b_q), .Q_n(b_qn), .RCO(b_rco));
  ttl_counter_n #(.WIDTH(8), .MODULUS(256), .UPDOWN(1)) u_c (.CLK(clk), .R(r), .S(s),
    .SCLR_n(sclr_n), .LD_n(ld_n), .D(d8), .ENP(enp), .ENT(ent), .UD(ud), .Q(c_q), .Q_n(c_qn),
    .RCO(c_rco));
  ttl_counter_n u_e0 (.CLK(clk), .R(r), .S(s), .SCLR_n(sclr_n), .LD_n(ld_n), .D(d8[3:0]),
    .ENP(enp), .ENT(ent), .UD(ud), .Q(e0_q), .Q_n(e0_qn), .RCO(e0_rco));
  ttl_counter_n u_e1 (.CLK(clk), .R(r), .S(s), .SCLR_n(sclr_n), .LD_n(ld_n), .D(d8[7:4]),
    .ENP(enp), .ENT(e0_rco), .UD(ud), .Q(e1_q), .Q_n(e1_qn), .RCO(e1_rco));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    r = 1'b0;
    #2;
    checks++; if (a_q !== 4'h0) begin errors++; $display("FAIL reset_q: got %0h want 0", a_q); end
    checks++; if (a_qn !== 4'hf) begin errors++; $display("FAIL reset_qn: got %0h want f", a_qn); end
    checks++; if (c_q !== 8'h00) begin errors++; $display("FAIL reset_q8: got %0h want 0", c_q); end
    checks++; if (a_rco !== 1'b0) begin errors++; $display("FAIL reset_rco: got %0b want 0", a_rco); end
    r = 1'b1;
    tick;
  endtask

  task automatic test_async_clear;
    enp = 1'b1; ent = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      exp_q.push_back(16'(i));
      tick;
      e = exp_q.pop_front();
      checks++; if (a_q !== e[3:0]) begin errors++; $display("FAIL count16: got %0h want %0h", a_q, e[3:0]); end
    end
    #3 r = 1'b0;
    #1;
    checks++; if (a_q !== 4'h0) begin errors++; $display("FAIL async_clr_q: got %0h want 0", a_q); end
    checks++; if (a_qn !== 4'hf) begin errors++; $display("FAIL async_clr_qn: got %0h want f", a_qn); end
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++; if (a_q !== 4'h0) begin errors++; $display("FAIL clr_held: got %0h want 0", a_q); end
    end
    r = 1'b1;
    #1;
    checks++; if (a_q !== 4'h0) begin errors++; $display("FAIL clr_release: got %0h want 0", a_q); end
    exp_q.push_back(16'd1);
    tick;
    e = exp_q.pop_front();
    checks++; if (a_q !== e[3:0]) begin errors++; $display("FAIL clr_resume: got %0h want %0h", a_q, e[3:0]); end
    enp = 1'b0; ent = 1'b0;
  endtask

  task automatic test_decade;
    ud = 1'b1;
    sclr_n = 1'b0;
    tick;
    sclr_n = 1'b1;
    checks++; if (b_q !== 4'h0) begin errors++; $display("FAIL sclr: got %0h want 0", b_q); end
    enp = 1'b1; ent = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      exp_q.push_back(16'(i % 10));
      tick;
      e = exp_q.pop_front();
      checks++; if (b_q !== e[3:0]) begin errors++; $display("FAIL decade_q: got %0h want %0h", b_q, e[3:0]); end
      checks++; if (b_rco !== (e == 16'd9)) begin errors++; $display("FAIL decade_rco: got %0b want %0b at q=%0h", b_rco, e == 16'd9, e[3:0]); end
    end
    d4 = 4'd9; ld_n = 1'b0; ent = 1'b0;
    tick;
    ld_n = 1'b1;
    checks++; if (b_q !== 4'h9) begin errors++; $display("FAIL load9: got %0h want 9", b_q); end
    checks++; if (b_rco !== 1'b0) begin errors++; $display("FAIL rco_ent0: got %0b want 0", b_rco); end
    tick;
    checks++; if (b_q !== 4'h9) begin errors++; $display("FAIL hold_ent0: got %0h want 9", b_q); end
    ent = 1'b1; enp = 1'b0;
    #1;
    checks++; if (b_rco !== 1'b1) begin errors++; $display("FAIL rco_enp0: got %0b want 1", b_rco); end
    tick;
    checks++; if (b_q !== 4'h9) begin errors++; $display("FAIL hold_enp0: got %0h want 9", b_q); end
    ent = 1'b0;
  endtask

  task automatic test_out_of_range;
    logic [3:0] up_seq[4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    logic [3:0] dn_seq[5] = '{4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
    enp = 1'b1; ent = 1'b1; ud = 1'b1;
    d4 = 4'd13; ld_n = 1'b0;
    tick;
    ld_n = 1'b1;
    checks++; if (b_q !== 4'hd) begin errors++; $display("FAIL load13: got %0h want d", b_q); end
    #2 d4 = 4'd4;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'(up_seq[i]));
      tick;
      e = exp_q.pop_front();
      checks++; if (b_q !== e[3:0]) begin errors++; $display("FAIL oor_up: got %0h want %0h", b_q, e[3:0]); end
    end
    d4 = 4'd13; ld_n = 1'b0;
    tick;
    ld_n = 1'b1; ud = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(16'(dn_seq[i]));
      tick;
      e = exp_q.pop_front();
      checks++; if (b_q !== e[3:0]) begin errors++; $display("FAIL oor_down: got %0h want %0h", b_q, e[3:0]); end
    end
    ud = 1'b1; enp = 1'b0; ent = 1'b0;
  endtask

  task automatic test_down8;
    logic [7:0] seq[4] = '{8'd1, 8'd0, 8'd255, 8'd254};
    ud = 1'b0; d8 = 8'd2; ld_n = 1'b0;
    tick;
    ld_n = 1'b1;
    checks++; if (c_q !== 8'd2) begin errors++; $display("FAIL load2: got %0h want 2", c_q); end
    enp = 1'b1; ent = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'(seq[i]));
      tick;
      e = exp_q.pop_front();
      checks++; if (c_q !== e[7:0]) begin errors++; $display("FAIL down8_q: got %0h want %0h", c_q, e[7:0]); end
      checks++; if (c_rco !== (e == 16'd0)) begin errors++; $display("FAIL down8_rco: got %0b want %0b", c_rco, e == 16'd0); end
    end
    ud = 1'b1; enp = 1'b0; ent = 1'b0;
  endtask

  task automatic test_async_priority;
    enp = 1'b1; ent = 1'b1;
    #3 r = 1'b0; s = 1'b0;
    #1;
    checks++; if (a_q !== 4'h0) begin errors++; $display("FAIL rs_low_q: got %0h want 0", a_q); end
    checks++; if (a_qn !== 4'hf) begin errors++; $display("FAIL rs_low_qn: got %0h want f", a_qn); end
    checks++; if (c_q !== 8'h00) begin errors++; $display("FAIL rs_low_q8: got %0h want 0", c_q); end
    tick;
    checks++; if (a_q !== 4'h0) begin errors++; $display("FAIL rs_low_edge: got %0h want 0", a_q); end
    #3 r = 1'b1;
    #1;
    checks++; if (a_q !== 4'hf) begin errors++; $display("FAIL preset_q: got %0h want f", a_q); end
    checks++; if (a_qn !== 4'h0) begin errors++; $display("FAIL preset_qn: got %0h want 0", a_qn); end
    checks++; if (c_q !== 8'hff) begin errors++; $display("FAIL preset_q8: got %0h want ff", c_q); end
    tick;
    checks++; if (a_q !== 4'hf) begin errors++; $display("FAIL preset_edge: got %0h want f", a_q); end
    s = 1'b1;
    #1;
    checks++; if (a_q !== 4'hf) begin errors++; $display("FAIL preset_release: got %0h want f", a_q); end
    exp_q.push_back(16'd0);
    tick;
    e = exp_q.pop_front();
    checks++; if (a_q !== e[3:0]) begin errors++; $display("FAIL preset_wrap: got %0h want %0h", a_q, e[3:0]); end
    sclr_n = 1'b0; ld_n = 1'b0; d4 = 4'd5;
    tick;
    sclr_n = 1'b1;
    checks++; if (a_q !== 4'h0) begin errors++; $display("FAIL sclr_over_ld: got %0h want 0", a_q); end
    tick;
    ld_n = 1'b1;
    checks++; if (a_q !== 4'h5) begin errors++; $display("FAIL ld_over_count: got %0h want 5", a_q); end
    enp = 1'b0; ent = 1'b0;
  endtask

  task automatic test_cascade;
    d8 = 8'h0e; ld_n = 1'b0;
    tick;
    ld_n = 1'b1;
    checks++; if ({e1_q, e0_q} !== 8'h0e) begin errors++; $display("FAIL casc_load: got %0h want 0e", {e1_q, e0_q}); end
    enp = 1'b1; ent = 1'b1;
    exp_q.push_back(16'h0f);
    exp_q.push_back(16'h10);
    tick;
    e = exp_q.pop_front();
    checks++; if ({e1_q, e0_q} !== e[7:0]) begin errors++; $display("FAIL casc_step1: got %0h want %0h", {e1_q, e0_q}, e[7:0]); end
    checks++; if (e0_rco !== 1'b1) begin errors++; $display("FAIL casc_rco: got %0b want 1", e0_rco); end
    tick;
    e = exp_q.pop_front();
    checks++; if ({e1_q, e0_q} !== e[7:0]) begin errors++; $display("FAIL casc_step2: got %0h want %0h", {e1_q, e0_q}, e[7:0]); end
    enp = 1'b0;
    tick;
    tick;
    checks++; if ({e1_q, e0_q} !== 8'h10) begin errors++; $display("FAIL casc_hold: got %0h want 10", {e1_q, e0_q}); end
    ent = 1'b0;
  endtask

  initial begin
    #1;
    test_reset;
    test_async_clear;
    test_decade;
    test_out_of_range;
    test_down8;
    test_async_priority;
    test_cascade;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
